// File: rtl/obi_mem_responder_if.sv
// Request/response bus between a core's OBI-style port and obi_mem_responder.
// slave = responder side, master = core/testbench side.
interface obi_mem_responder_if;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        stall_i;
    logic        rvalid_stall_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i, stall_i, rvalid_stall_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i, stall_i, rvalid_stall_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/obi_mem_responder.sv
// Stall-injectable word memory behind an OBI-style req/gnt/rvalid port with an in-order response FIFO.
// Optional feature macro: OBI_RESP_OOR_ERR_EN (out-of-range detection and sticky err_o).
module obi_mem_responder #(
    parameter int AW              = 8,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic               clk_i,
    input logic               rst_i,
    obi_mem_responder_if.slave bus
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = 3;

    logic [31:0]   mem_q  [2**AW];
    logic [31:0]   fifo_q [MAX_OUTSTANDING];

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    logic          grant;
    logic          pop;
    logic          oor;
    logic [AW-1:0] idx;
    logic [31:0]   push_data;
    logic          unused_addr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign idx         = bus.addr_i[AW+1:2];
    assign unused_addr = ^{bus.addr_i[1:0], bus.addr_i[31:AW+2]};

    // A same-cycle pop does not free a slot: grant looks only at the registered count.
    assign grant = bus.req_i & ~bus.stall_i & ~rst_i & (count_q < CW'(MAX_OUTSTANDING));
    assign pop   = (count_q != '0) & ~bus.rvalid_stall_i;

    assign bus.gnt_o    = grant;
    assign bus.rvalid_o = pop;
    assign bus.rdata_o  = pop ? fifo_q[rd_ptr_q] : 32'h0;

`ifdef OBI_RESP_OOR_ERR_EN
    logic err_q, err_d;

    assign oor       = |bus.addr_i[31:AW+2];
    assign err_d     = err_q | (grant & oor);
    assign bus.err_o = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end
`else
    assign oor       = 1'b0;
    assign bus.err_o = 1'b0;
`endif

    assign push_data = bus.we_i ? 32'h0 : (oor ? 32'hDEAD_BEEF : mem_q[idx]);

    always_comb begin
        wr_ptr_d = grant ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop   ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        unique case ({grant, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Memory and FIFO payload are deliberately outside reset so contents survive it.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            if (bus.we_i && !oor) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.be_i[b]) mem_q[idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
                end
            end
            fifo_q[wr_ptr_q] <= push_data;
        end
    end
endmodule

// File: tb/tb_obi_mem_responder.sv
// Self-checking bench for obi_mem_responder: vector table, scoreboard queue and corner-case sequences.
// Honours OBI_RESP_OOR_ERR_EN to pick the expected out-of-range behaviour.
module tb_obi_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    obi_mem_responder_if bus();

    obi_mem_responder #(.AW(8), .MAX_OUTSTANDING(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] data;
        int          gcyc;
    } sb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[12];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   lat_chk = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        bus.req_i   = req;
        bus.we_i    = we;
        bus.addr_i  = addr;
        bus.be_i    = be;
        bus.wdata_i = wd;
    endtask

    // Drive a request and wait (bounded) for its grant; push the expected response on grant.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] exp, input string tag,
                         output int waits);
        bit got;
        got   = 1'b0;
        waits = 0;
        @(posedge clk); #1;
        drive(1'b1, we, addr, be, wd);
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (bus.gnt_o) begin
                sb_q.push_back('{exp, cyc});
                got = 1'b1;
                $display("txn %s: %s addr=%h be=%b wdata=%h granted cycle %0d",
                         tag, we ? "WR" : "RD", addr, be, wd, cyc);
            end else begin
                waits++;
            end
        end
        check({tag, "_gnt"}, 32'(got), 32'd1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 20 && sb_q.size() != 0; n++) @(posedge clk);
        check({tag, "_drain"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int          w;
        logic [31:0] exp_oor_rd;
        logic        exp_err;
        logic [31:0] exp_rd0;

        vecs[0]  = '{1'b1, 32'h0000_0010, 4'b1111, 32'h1234_5678, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 4'b0000, 32'h0,         32'h1234_5678};
        vecs[2]  = '{1'b1, 32'h0000_0020, 4'b1111, 32'h0,         32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0020, 4'b0101, 32'hAABB_CCDD, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0020, 4'b0000, 32'h0,         32'h00BB_00DD};
        vecs[5]  = '{1'b1, 32'h0000_0000, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_03FC, 4'b1111, 32'hFFFF_FFFF, 32'h0};
        vecs[7]  = '{1'b1, 32'h0000_03FE, 4'b0110, 32'h1234_5678, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_03FC, 4'b0000, 32'h0,         32'hFF34_56FF};
        vecs[9]  = '{1'b1, 32'h0000_0010, 4'b0000, 32'hFFFF_FFFF, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_0010, 4'b0000, 32'h0,         32'h1234_5678};
        vecs[11] = '{1'b0, 32'h0000_0003, 4'b0000, 32'h0,         32'hCAFE_F00D};

`ifdef OBI_RESP_OOR_ERR_EN
        exp_oor_rd = 32'hDEAD_BEEF;
        exp_err    = 1'b1;
        exp_rd0    = 32'hCAFE_F00D;
`else
        exp_oor_rd = 32'hCAFE_F00D;
        exp_err    = 1'b0;
        exp_rd0    = 32'h0000_0099;
`endif

        bus.stall_i        = 1'b0;
        bus.rvalid_stall_i = 1'b0;
        drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);

        // Response monitor: pops the scoreboard on every rvalid, checks idle rdata otherwise.
        fork
            forever begin
                @(negedge clk);
                if (bus.rvalid_o) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_rvalid", {31'h0, bus.rvalid_o}, 32'h0);
                    end else begin
                        sb_t e;
                        e = sb_q.pop_front();
                        $display("rsp data=%h cycle %0d (granted %0d)", bus.rdata_o, cyc, e.gcyc);
                        check("rdata", bus.rdata_o, e.data);
                        if (lat_chk) check("latency", 32'(cyc - e.gcyc), 32'd1);
                    end
                end else begin
                    check("idle_rdata", bus.rdata_o, 32'h0);
                end
            end
        join_none

        // Reset state with req held high.
        #12;
        check("rst_gnt",    {31'h0, bus.gnt_o},    32'h0);
        check("rst_rvalid", {31'h0, bus.rvalid_o}, 32'h0);
        check("rst_rdata",  bus.rdata_o,           32'h0);
        check("rst_err",    {31'h0, bus.err_o},    32'h0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst = 1'b0;

        // Back-to-back vector table: one grant per cycle, one-cycle response latency.
        lat_chk = 1'b1;
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].exp, $sformatf("v%0d", i), w);
            check($sformatf("v%0d_b2b", i), 32'(w), 32'd0);
        end
        idle();
        drain("table");
        check("err_in_range", {31'h0, bus.err_o}, 32'h0);

        // Outstanding limit with response stall; a pop does not free a slot in its own cycle.
        lat_chk = 1'b0;
        @(posedge clk); #1;
        bus.rvalid_stall_i = 1'b1;
        issue(1'b0, 32'h10, 4'h0, 32'h0, 32'h1234_5678, "s1", w);
        issue(1'b0, 32'h20, 4'h0, 32'h0, 32'h00BB_00DD, "s2", w);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        check("full_gnt1", {31'h0, bus.gnt_o}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("full_gnt2", {31'h0, bus.gnt_o}, 32'h0);
        @(posedge clk); #1;
        bus.rvalid_stall_i = 1'b0;
        @(negedge clk);
        check("pop_rvalid",  {31'h0, bus.rvalid_o}, 32'h1);
        check("pop_no_slot", {31'h0, bus.gnt_o},    32'h0);
        @(negedge clk);
        check("third_gnt", {31'h0, bus.gnt_o}, 32'h1);
        if (bus.gnt_o) sb_q.push_back('{32'hCAFE_F00D, cyc});
        idle();
        drain("stall");

        // Grant stall for three cycles, grant on the fourth, response on the fifth.
        lat_chk = 1'b1;
        @(posedge clk); #1;
        bus.stall_i = 1'b1;
        drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("stall_gnt%0d", i), {31'h0, bus.gnt_o}, 32'h0);
        end
        @(posedge clk); #1;
        bus.stall_i = 1'b0;
        @(negedge clk);
        check("stall_release_gnt", {31'h0, bus.gnt_o}, 32'h1);
        if (bus.gnt_o) sb_q.push_back('{32'h1234_5678, cyc});
        idle();
        drain("gstall");

        // Reset with two responses pending: they are discarded, memory survives.
        lat_chk = 1'b0;
        @(posedge clk); #1;
        bus.rvalid_stall_i = 1'b1;
        issue(1'b1, 32'h40, 4'hF, 32'h5A5A_5A5A, 32'h0, "r1", w);
        issue(1'b0, 32'h10, 4'h0, 32'h0, 32'h1234_5678, "r2", w);
        @(posedge clk); #1;
        bus.rvalid_stall_i = 1'b0;
        drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        #1;
        check("pre_rst_rvalid", {31'h0, bus.rvalid_o}, 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_rvalid", {31'h0, bus.rvalid_o}, 32'h0);
        check("mid_rst_rdata",  bus.rdata_o,           32'h0);
        check("mid_rst_gnt",    {31'h0, bus.gnt_o},    32'h0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_quiet%0d", i), {31'h0, bus.rvalid_o}, 32'h0);
        end
        lat_chk = 1'b1;
        issue(1'b0, 32'h40, 4'h0, 32'h0, 32'h5A5A_5A5A, "r3", w);
        issue(1'b0, 32'h10, 4'h0, 32'h0, 32'h1234_5678, "r4", w);
        idle();
        drain("reset");
        check("post_rst_err", {31'h0, bus.err_o}, 32'h0);

        // Out-of-range access: error path with the macro, aliasing without it.
        issue(1'b0, 32'h8000_0000, 4'h0, 32'h0, exp_oor_rd, "oor_rd", w);
        idle();
        @(negedge clk);
        check("oor_err", {31'h0, bus.err_o}, {31'h0, exp_err});
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("oor_err_sticky", {31'h0, bus.err_o}, {31'h0, exp_err});
        issue(1'b1, 32'h8000_0000, 4'hF, 32'h0000_0099, 32'h0, "oor_wr", w);
        issue(1'b0, 32'h0000_0000, 4'h0, 32'h0, exp_rd0, "rd0", w);
        idle();
        drain("oor");
        check("final_err", {31'h0, bus.err_o}, {31'h0, exp_err});

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
